fx2_fifo_reader: RTL and testbench

Receive-side FX2LP synchronous slave-FIFO master: reads bytes from an FX2LP OUT endpoint and reassembles them into 32-bit {Q[15:0], I[15:0]} words. Output is a valid/ready stream feeding the transmit path (interpolator/NCO upconverter/DAC on ADDA). It is the counterpart of the IN-endpoint byte writer and runs on the 48 MHz IFCLK domain, with IFCLK connected to clk.

---
 rtl/fx2_fifo_reader.sv | 152 +++++++++++++++
 tb/tb_fx2_fifo_reader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx2_fifo_reader.sv
// Purpose: FX2LP slave-FIFO master that reads an OUT endpoint and packs bytes into 32-bit {Q,I} words.
// Latency: 2 clk from the 4th SLRD cycle to out_valid; one byte per 1+GAP_CYCLES clk at best.
// Backpressure: a full, unconsumed out register parks the FSM in DONE, so no further SLRD strobes are issued.
module fx2_fifo_reader #(
    parameter logic [1:0]  FIFO_ADDR       = 2'b00,
    parameter int          GAP_CYCLES      = 2,
    // Reset value of word_count; nonzero lets the wrap point be reached without 2^32 words.
    parameter logic [31:0] WORD_COUNT_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        sync_clear,
    input  logic [7:0]  fd_in,
    input  logic        flag_empty_n,
    output logic        sloen,
    output logic        slrdn,
    output logic [1:0]  fifoadr,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] word_count,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OE,
        S_RD,
        S_GAP,
        S_DONE
    } state_t;

    // Gap count after a byte strobe: GAP_CYCLES idle cycles, the last of which samples the flag.
    localparam logic [3:0] GAP_LOAD_BYTE = 4'(GAP_CYCLES - 1);
    // After the last byte of a word the DONE cycle already idles the bus for one cycle,
    // so the following gap is one cycle shorter (but GAP always lasts at least one cycle).
    localparam logic [3:0] GAP_LOAD_WORD = (GAP_CYCLES > 1) ? 4'(GAP_CYCLES - 2) : 4'd0;

    state_t      state;
    logic [1:0]  byte_idx;
    logic [31:0] asm_word;
    logic [3:0]  gap_cnt;

    logic        out_free;
    logic        handshake;
    logic        load_word;

    assign fifoadr   = FIFO_ADDR;
    assign busy      = (state != S_IDLE);
    assign handshake = out_valid & out_ready;
    assign out_free  = ~out_valid | out_ready;
    // A completed word moves out only when the slot is free; sync_clear leaves the out register alone.
    assign load_word = (state == S_DONE) && out_free && !sync_clear;

    // Read sequencer: drives SLOE/SLRD, paces strobes and assembles bytes little-endian.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            sloen    <= 1'b1;
            slrdn    <= 1'b1;
            byte_idx <= 2'd0;
            asm_word <= 32'h0;
            gap_cnt  <= 4'd0;
        end else if (sync_clear) begin
            state    <= S_IDLE;
            sloen    <= 1'b1;
            slrdn    <= 1'b1;
            byte_idx <= 2'd0;
            asm_word <= 32'h0;
            gap_cnt  <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    sloen <= 1'b1;
                    slrdn <= 1'b1;
                    // Only start a word when it can eventually be handed off.
                    if (enable && flag_empty_n && out_free) begin
                        state <= S_OE;
                        sloen <= 1'b0;
                    end
                end
                S_OE: begin
                    // Bus turnaround: FX2 starts driving FD this cycle.
                    state <= S_RD;
                    slrdn <= 1'b0;
                end
                S_RD: begin
                    asm_word[{byte_idx, 3'b000} +: 8] <= fd_in;
                    slrdn <= 1'b1;
                    if (byte_idx != 2'd3) begin
                        byte_idx <= byte_idx + 2'd1;
                        gap_cnt  <= GAP_LOAD_BYTE;
                        state    <= S_GAP;
                    end else begin
                        byte_idx <= 2'd0;
                        state    <= S_DONE;
                    end
                end
                S_GAP: begin
                    // Partial word is held here while the endpoint is empty; enable is ignored mid-word.
                    if (gap_cnt != 4'd0) begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end else if (flag_empty_n) begin
                        state <= S_RD;
                        slrdn <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (out_free) begin
                        if (enable && flag_empty_n) begin
                            gap_cnt <= GAP_LOAD_WORD;
                            state   <= S_GAP;
                        end else begin
                            state <= S_IDLE;
                            sloen <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    sloen    <= 1'b1;
                    slrdn    <= 1'b1;
                    byte_idx <= 2'd0;
                end
            endcase
        end
    end

    // One-entry output register; a load in the handshake cycle keeps out_valid high.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= 32'h0;
        end else if (load_word) begin
            out_valid <= 1'b1;
            out_data  <= asm_word;
        end else if (handshake) begin
            out_valid <= 1'b0;
        end
    end

    // Count of words accepted downstream, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_count <= WORD_COUNT_INIT;
        end else if (handshake) begin
            word_count <= word_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fx2_fifo_reader.sv
// Bench for fx2_fifo_reader: FX2 byte-queue model, table-driven first word, directed corner sequences.
// A second instance starts its word counter at all-ones to observe the wrap.
// All outputs are sampled 1 time unit after the rising edge.
module tb_fx2_fifo_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        sync_clear;
    logic [7:0]  fd_in;
    logic        flag_empty_n;
    logic        out_ready;

    logic        sloen, slrdn, out_valid, busy;
    logic [1:0]  fifoadr;
    logic [31:0] out_data, word_count;

    logic        w_sloen, w_slrdn, w_out_valid, w_busy;
    logic [1:0]  w_fifoadr;
    logic [31:0] w_out_data, w_word_count;

    always #5 clk = ~clk;

    fx2_fifo_reader dut (
        .clk(clk), .reset(reset), .enable(enable), .sync_clear(sync_clear),
        .fd_in(fd_in), .flag_empty_n(flag_empty_n),
        .sloen(sloen), .slrdn(slrdn), .fifoadr(fifoadr),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .word_count(word_count), .busy(busy)
    );

    fx2_fifo_reader #(.WORD_COUNT_INIT(32'hFFFF_FFFF)) dut_wrap (
        .clk(clk), .reset(reset), .enable(enable), .sync_clear(sync_clear),
        .fd_in(fd_in), .flag_empty_n(flag_empty_n),
        .sloen(w_sloen), .slrdn(w_slrdn), .fifoadr(w_fifoadr),
        .out_data(w_out_data), .out_valid(w_out_valid), .out_ready(out_ready),
        .word_count(w_word_count), .busy(w_busy)
    );

    int total = 0;
    int bad   = 0;

    // FX2 OUT endpoint model
    logic [7:0] mem [0:63];
    int rd_ptr, wr_ptr, pops, cyc, consec;
    int pulse_t [0:15];
    logic prev_low;

    typedef struct {
        logic        enable;
        logic        out_ready;
        logic        sloen;
        logic        slrdn;
        logic        busy;
        logic        out_valid;
        logic [31:0] data;
        logic [31:0] wc;
    } vec_t;

    vec_t vt [0:14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic update_fx2();
        flag_empty_n = (rd_ptr < wr_ptr);
        fd_in        = (rd_ptr < wr_ptr) ? mem[rd_ptr] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
        update_fx2();
    endtask

    task automatic tick();
        logic strobe;
        strobe = !slrdn && !sloen;
        @(posedge clk);
        #1;
        cyc++;
        if (strobe) begin
            if (pops < 16) pulse_t[pops] = cyc - 1;
            pops++;
            rd_ptr++;
        end
        if (!slrdn && prev_low) consec++;
        prev_low = !slrdn;
        update_fx2();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pops = 0;
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (pops < n && k < budget) begin
            tick();
            k++;
        end
        check(name, 32'(pops >= n), 32'd1);
    endtask

    task automatic wait_valid(input int budget, input string name);
        int k;
        k = 0;
        while (!out_valid && k < budget) begin
            tick();
            k++;
        end
        check(name, 32'(out_valid), 32'd1);
    endtask

    initial begin
        // Expected per-cycle outputs for one word 11,22,33,44 with GAP_CYCLES=2
        //            en  rdy sloen slrdn busy ov  data           wc
        vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'd0}; // OE
        vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'd0}; // RD b0
        vt[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'd0};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'd0};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'd0}; // RD b1
        vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'd0};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'd0};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'd0}; // RD b2
        vt[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'd0};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'd0};
        vt[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'd0}; // RD b3
        vt[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'd0}; // DONE
        vt[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h44332211, 32'd0}; // word out
        vt[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h44332211, 32'd1}; // accepted
        vt[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h44332211, 32'd1};

        reset = 1'b1; enable = 1'b0; sync_clear = 1'b0; out_ready = 1'b0;
        rd_ptr = 0; wr_ptr = 0; pops = 0; cyc = 0; consec = 0; prev_low = 1'b0;
        update_fx2();
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst sloen",   32'(sloen),     32'd1);
        check("rst slrdn",   32'(slrdn),     32'd1);
        check("rst fifoadr", 32'(fifoadr),   32'd0);
        check("rst valid",   32'(out_valid), 32'd0);
        check("rst data",    out_data,       32'h0);
        check("rst wc",      word_count,     32'h0);
        check("rst busy",    32'(busy),      32'd0);
        check("rst wrap wc", w_word_count,   32'hFFFF_FFFF);
        check("rst wrap fifoadr", 32'(w_fifoadr), 32'd0);
        reset = 1'b0;

        // Byte assembly, cycle by cycle
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        for (int i = 0; i < 15; i++) begin
            enable    = vt[i].enable;
            out_ready = vt[i].out_ready;
            tick();
            check($sformatf("row%0d ctrl", i), 32'({sloen, slrdn, busy, out_valid}),
                  32'({vt[i].sloen, vt[i].slrdn, vt[i].busy, vt[i].out_valid}));
            check($sformatf("row%0d data", i), out_data, vt[i].data);
            check($sformatf("row%0d wc", i), word_count, vt[i].wc);
            check($sformatf("row%0d wrap ctrl", i), 32'({w_sloen, w_slrdn, w_busy, w_out_valid}),
                  32'({vt[i].sloen, vt[i].slrdn, vt[i].busy, vt[i].out_valid}));
            check($sformatf("row%0d wrap data", i), w_out_data, vt[i].data);
        end
        check("asm pulses",  32'(pops), 32'd4);
        check("asm spacing", 32'(pulse_t[1] - pulse_t[0]), 32'd3);
        check("asm span",    32'(pulse_t[3] - pulse_t[0]), 32'd9);
        check("wrap wc",     w_word_count, 32'h0);

        // Empty mid-word: only two bytes available, endpoint then stays empty for 20 clk
        enable = 1'b1; out_ready = 1'b1; pops = 0;
        push(8'hA1); push(8'hB2);
        wait_pops(2, 40, "empty first bytes");
        repeat (20) tick();
        check("empty no strobes", 32'(pops), 32'd2);
        check("empty busy",       32'(busy), 32'd1);
        check("empty sloen",      32'(sloen), 32'd0);
        check("empty valid",      32'(out_valid), 32'd0);
        push(8'hC3); push(8'hD4);
        wait_valid(40, "empty word done");
        check("empty data",  out_data, 32'hD4C3B2A1);
        check("empty pops",  32'(pops), 32'd4);
        tick();
        check("empty wc",    word_count, 32'd2);

        // Backpressure: 8 bytes, downstream stalled
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        repeat (60) tick();
        check("bp pops",         32'(pops), 32'd8);
        check("bp byte period",  32'(pulse_t[1] - pulse_t[0]), 32'd3);
        check("bp word period",  32'(pulse_t[4] - pulse_t[0]), 32'd12);
        check("bp held valid",   32'(out_valid), 32'd1);
        check("bp held data",    out_data, 32'h04030201);
        check("bp done busy",    32'(busy), 32'd1);
        check("bp done slrdn",   32'(slrdn), 32'd1);
        check("bp wc stalled",   word_count, 32'd0);
        repeat (20) tick();
        check("bp no extra strobes", 32'(pops), 32'd8);
        out_ready = 1'b1;
        tick();
        check("bp reload valid", 32'(out_valid), 32'd1);
        check("bp second data",  out_data, 32'h08070605);
        check("bp wc one",       word_count, 32'd1);
        tick();
        check("bp drained",      32'(out_valid), 32'd0);
        check("bp wc two",       word_count, 32'd2);

        // sync_clear after byte 1
        do_reset();
        out_ready = 1'b1; enable = 1'b1;
        push(8'h55); push(8'h66); push(8'h77); push(8'h88);
        wait_pops(1, 20, "sc first byte");
        sync_clear = 1'b1;
        tick();
        sync_clear = 1'b0;
        check("sc sloen", 32'(sloen), 32'd1);
        check("sc slrdn", 32'(slrdn), 32'd1);
        check("sc idle",  32'(busy),  32'd0);
        push(8'h99);
        wait_valid(60, "sc next word");
        check("sc realigned data", out_data, 32'h99887766);
        tick();
        check("sc wc", word_count, 32'd1);

        // Reset mid-read with a word held and another in progress
        out_ready = 1'b0; pops = 0;
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
        wait_valid(60, "mr first word");
        begin
            int k;
            k = 0;
            while (slrdn && k < 20) begin
                tick();
                k++;
            end
        end
        check("mr in RD", 32'(slrdn), 32'd0);
        reset = 1'b1;
        tick();
        check("mr sloen",   32'(sloen),     32'd1);
        check("mr slrdn",   32'(slrdn),     32'd1);
        check("mr valid",   32'(out_valid), 32'd0);
        check("mr data",    out_data,       32'h0);
        check("mr wc",      word_count,     32'h0);
        check("mr busy",    32'(busy),      32'd0);
        check("mr fifoadr", 32'(fifoadr),   32'd0);
        reset = 1'b0;
        tick();

        check("slrdn never two cycles low", 32'(consec), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
